// File: rtl/apb5_pkg.sv
// Shared types and constants for the APB5 rev D multi-requester arbiter.
// Imported by the round-robin arbiter and the top-level sequencer.
package apb5_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StWake   = 2'd1,
        StSetup  = 2'd2,
        StAccess = 2'd3
    } apb5_state_e;

    // Bit positions within pprot[2:0]
    localparam int unsigned PPROT_PRIV   = 0;
    localparam int unsigned PPROT_NONSEC = 1;
    localparam int unsigned PPROT_INSTR  = 2;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/apb5_rr_arbiter.sv
// Round-robin arbiter: the search starts one past the previous winner and the
// pointer only moves when the caller accepts the grant via advance_i.
module apb5_rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = 2
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               advance_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   gnt_idx_o,
    output logic               gnt_valid_o
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] idx;

    always_comb begin
        gnt_o       = '0;
        gnt_idx_o   = '0;
        gnt_valid_o = 1'b0;
        idx         = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = IDX_W'((32'(ptr_q) + i) % NUM_REQ);
            if (!gnt_valid_o && req_i[idx]) begin
                gnt_valid_o = 1'b1;
                gnt_idx_o   = idx;
                gnt_o[idx]  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else if (advance_i && gnt_valid_o) begin
            ptr_q <= (gnt_idx_o == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx_o + 1'b1;
        end
    end

endmodule

// File: rtl/apb5_rev_d_arbiter.sv
// Shares one APB5 completer among NUM_REQ requesters: round-robin grant,
// WAKE/SETUP/ACCESS sequencing with pwakeup, and response return to the winner.
module apb5_rev_d_arbiter
    import apb5_pkg::*;
#(
    parameter int unsigned NUM_REQ         = 4,
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned USER_REQ_WIDTH  = 4,
    parameter int unsigned USER_DATA_WIDTH = 4,
    parameter int unsigned USER_RESP_WIDTH = 4
) (
    input  logic                                          pclk,
    input  logic                                          presetn,
    // Requester side
    input  logic [NUM_REQ-1:0]                            req_valid,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]            req_addr,
    input  logic [NUM_REQ-1:0]                            req_write,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]            req_wdata,
    input  logic [NUM_REQ-1:0][DATA_WIDTH/8-1:0]          req_strb,
    input  logic [NUM_REQ-1:0][2:0]                       req_prot,
    input  logic [NUM_REQ-1:0][USER_REQ_WIDTH-1:0]        req_auser,
    input  logic [NUM_REQ-1:0][USER_DATA_WIDTH-1:0]       req_wuser,
    output logic [NUM_REQ-1:0]                            req_gnt,
    output logic [NUM_REQ-1:0]                            rsp_done,
    output logic [DATA_WIDTH-1:0]                         rsp_rdata,
    output logic                                          rsp_slverr,
    output logic [USER_DATA_WIDTH-1:0]                    rsp_ruser,
    output logic [USER_RESP_WIDTH-1:0]                    rsp_buser,
    // APB5 manager side
    output logic [ADDR_WIDTH-1:0]                         paddr,
    output logic [2:0]                                    pprot,
    output logic                                          psel,
    output logic                                          penable,
    output logic                                          pwrite,
    output logic [DATA_WIDTH-1:0]                         pwdata,
    output logic [DATA_WIDTH/8-1:0]                       pstrb,
    output logic                                          pwakeup,
    output logic [USER_REQ_WIDTH-1:0]                     pauser,
    output logic [USER_DATA_WIDTH-1:0]                    pwuser,
    input  logic                                          pready,
    input  logic [DATA_WIDTH-1:0]                         prdata,
    input  logic                                          pslverr,
    input  logic [USER_DATA_WIDTH-1:0]                    pruser,
    input  logic [USER_RESP_WIDTH-1:0]                    pbuser
);

    localparam int unsigned IDX_W  = idx_width(NUM_REQ);
    localparam int unsigned STRB_W = DATA_WIDTH / 8;

    apb5_state_e state_q, state_d;

    logic [NUM_REQ-1:0] arb_gnt;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_valid;
    logic               grant_now;
    logic               complete;

    logic [NUM_REQ-1:0]         owner_q;
    logic [NUM_REQ-1:0]         req_gnt_q, rsp_done_q;
    logic                       psel_q, penable_q, pwakeup_q, pwrite_q;
    logic [ADDR_WIDTH-1:0]      paddr_q;
    logic [DATA_WIDTH-1:0]      pwdata_q, rsp_rdata_q;
    logic [STRB_W-1:0]          pstrb_q;
    logic [2:0]                 pprot_q;
    logic [USER_REQ_WIDTH-1:0]  pauser_q;
    logic [USER_DATA_WIDTH-1:0] pwuser_q, rsp_ruser_q;
    logic [USER_RESP_WIDTH-1:0] rsp_buser_q;
    logic                       rsp_slverr_q;

    apb5_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .clk_i       (pclk),
        .rst_ni      (presetn),
        .req_i       (req_valid),
        .advance_i   (grant_now),
        .gnt_o       (arb_gnt),
        .gnt_idx_o   (arb_idx),
        .gnt_valid_o (arb_valid)
    );

    assign complete = (state_q == StAccess) && pready;

    always_comb begin
        state_d   = state_q;
        grant_now = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (arb_valid) begin
                    grant_now = 1'b1;
                    state_d   = StWake;
                end
            end
            StWake:  state_d = StSetup;
            StSetup: state_d = StAccess;
            StAccess: begin
                if (pready) begin
                    // Chaining straight into SETUP keeps pwakeup high and skips WAKE
                    if (arb_valid) begin
                        grant_now = 1'b1;
                        state_d   = StSetup;
                    end else begin
                        state_d   = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q    <= StIdle;
            psel_q     <= 1'b0;
            penable_q  <= 1'b0;
            pwakeup_q  <= 1'b0;
            owner_q    <= '0;
            req_gnt_q  <= '0;
            rsp_done_q <= '0;
        end else begin
            state_q    <= state_d;
            psel_q     <= (state_d == StSetup) || (state_d == StAccess);
            penable_q  <= (state_d == StAccess);
            pwakeup_q  <= (state_d != StIdle);
            req_gnt_q  <= grant_now ? arb_gnt : '0;
            // owner_q still names the finishing transfer when a new grant lands
            rsp_done_q <= complete ? owner_q : '0;
            if (grant_now) begin
                owner_q <= arb_gnt;
            end
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            pwdata_q <= '0;
            pstrb_q  <= '0;
            pprot_q  <= '0;
            pauser_q <= '0;
            pwuser_q <= '0;
        end else if (grant_now) begin
            paddr_q              <= req_addr[arb_idx];
            pwrite_q             <= req_write[arb_idx];
            pwdata_q             <= req_wdata[arb_idx];
            pstrb_q              <= req_write[arb_idx] ? req_strb[arb_idx] : '0;
            pprot_q[PPROT_PRIV]   <= req_prot[arb_idx][PPROT_PRIV];
            pprot_q[PPROT_NONSEC] <= req_prot[arb_idx][PPROT_NONSEC];
            pprot_q[PPROT_INSTR]  <= req_prot[arb_idx][PPROT_INSTR];
            pauser_q             <= req_auser[arb_idx];
            pwuser_q             <= req_wuser[arb_idx];
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            rsp_rdata_q  <= '0;
            rsp_slverr_q <= 1'b0;
            rsp_ruser_q  <= '0;
            rsp_buser_q  <= '0;
        end else if (complete) begin
            rsp_rdata_q  <= prdata;
            rsp_slverr_q <= pslverr;
            rsp_ruser_q  <= pruser;
            rsp_buser_q  <= pbuser;
        end
    end

    assign req_gnt    = req_gnt_q;
    assign rsp_done   = rsp_done_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign rsp_slverr = rsp_slverr_q;
    assign rsp_ruser  = rsp_ruser_q;
    assign rsp_buser  = rsp_buser_q;
    assign paddr      = paddr_q;
    assign pprot      = pprot_q;
    assign psel       = psel_q;
    assign penable    = penable_q;
    assign pwrite     = pwrite_q;
    assign pwdata     = pwdata_q;
    assign pstrb      = pstrb_q;
    assign pwakeup    = pwakeup_q;
    assign pauser     = pauser_q;
    assign pwuser     = pwuser_q;

endmodule

// File: tb/tb_apb5_rev_d_arbiter.sv
// Directed bench for apb5_rev_d_arbiter: expected grants and responses are queued
// by the stimulus and popped by a monitor whenever req_gnt or rsp_done pulses.
module tb_apb5_rev_d_arbiter;

    localparam int unsigned N = 4;

    logic             pclk;
    logic             presetn;
    logic [N-1:0]     req_valid;
    logic [N-1:0][31:0] req_addr;
    logic [N-1:0]     req_write;
    logic [N-1:0][31:0] req_wdata;
    logic [N-1:0][3:0] req_strb;
    logic [N-1:0][2:0] req_prot;
    logic [N-1:0][3:0] req_auser;
    logic [N-1:0][3:0] req_wuser;
    logic [N-1:0]     req_gnt, rsp_done;
    logic [31:0]      rsp_rdata;
    logic             rsp_slverr;
    logic [3:0]       rsp_ruser, rsp_buser;
    logic [31:0]      paddr, pwdata, prdata;
    logic [2:0]       pprot;
    logic             psel, penable, pwrite, pwakeup, pready, pslverr;
    logic [3:0]       pstrb, pauser, pwuser, pruser, pbuser;

    typedef struct packed {
        logic [3:0]  who;
        logic [31:0] rdata;
        logic        slverr;
        logic [3:0]  ruser;
        logic [3:0]  buser;
    } rsp_t;

    rsp_t       rsp_q[$];
    logic [3:0] gnt_q[$];
    rsp_t       mon_e;
    logic [3:0] mon_g;
    int         checks = 0;
    int         failures = 0;
    int         wait_cfg = 0;
    int         wcnt = 0;

    apb5_rev_d_arbiter #(
        .NUM_REQ         (N),
        .ADDR_WIDTH      (32),
        .DATA_WIDTH      (32),
        .USER_REQ_WIDTH  (4),
        .USER_DATA_WIDTH (4),
        .USER_RESP_WIDTH (4)
    ) dut (
        .pclk       (pclk),
        .presetn    (presetn),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_write  (req_write),
        .req_wdata  (req_wdata),
        .req_strb   (req_strb),
        .req_prot   (req_prot),
        .req_auser  (req_auser),
        .req_wuser  (req_wuser),
        .req_gnt    (req_gnt),
        .rsp_done   (rsp_done),
        .rsp_rdata  (rsp_rdata),
        .rsp_slverr (rsp_slverr),
        .rsp_ruser  (rsp_ruser),
        .rsp_buser  (rsp_buser),
        .paddr      (paddr),
        .pprot      (pprot),
        .psel       (psel),
        .penable    (penable),
        .pwrite     (pwrite),
        .pwdata     (pwdata),
        .pstrb      (pstrb),
        .pwakeup    (pwakeup),
        .pauser     (pauser),
        .pwuser     (pwuser),
        .pready     (pready),
        .prdata     (prdata),
        .pslverr    (pslverr),
        .pruser     (pruser),
        .pbuser     (pbuser)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Completer model: pready rises after wait_cfg ACCESS cycles
    initial begin
        pready = 1'b0;
        forever begin
            @(negedge pclk);
            if (psel && penable) begin
                pready = (wcnt == wait_cfg);
                wcnt++;
            end else begin
                pready = 1'b0;
                wcnt   = 0;
            end
        end
    end

    // Monitor: pop and compare whenever the DUT pulses a grant or a completion
    always @(negedge pclk) begin
        if (req_gnt != '0) begin
            if (gnt_q.size() == 0) begin
                check("unexpected_gnt", 64'(req_gnt), 64'd0);
            end else begin
                mon_g = gnt_q.pop_front();
                check("gnt_order", 64'(req_gnt), 64'(mon_g));
            end
        end
        if (rsp_done != '0) begin
            if (rsp_q.size() == 0) begin
                check("unexpected_done", 64'(rsp_done), 64'd0);
            end else begin
                mon_e = rsp_q.pop_front();
                check("rsp_who", 64'(rsp_done), 64'(mon_e.who));
                check("rsp_rdata", 64'(rsp_rdata), 64'(mon_e.rdata));
                check("rsp_slverr", 64'(rsp_slverr), 64'(mon_e.slverr));
                check("rsp_ruser", 64'(rsp_ruser), 64'(mon_e.ruser));
                check("rsp_buser", 64'(rsp_buser), 64'(mon_e.buser));
            end
        end
    end

    task automatic set_req(input int i, input logic [31:0] a, input logic w, input logic [31:0] d,
                           input logic [3:0] s, input logic [2:0] p, input logic [3:0] au,
                           input logic [3:0] wu);
        req_addr[i]  = a;
        req_write[i] = w;
        req_wdata[i] = d;
        req_strb[i]  = s;
        req_prot[i]  = p;
        req_auser[i] = au;
        req_wuser[i] = wu;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctrl"}, 64'({psel, penable, pwakeup, pwrite, req_gnt, rsp_done}), 64'd0);
        check({tag, "_paddr"}, 64'(paddr), 64'd0);
        check({tag, "_pwdata"}, 64'(pwdata), 64'd0);
        check({tag, "_attr"}, 64'({pstrb, pprot, pauser, pwuser}), 64'd0);
        check({tag, "_rdata"}, 64'(rsp_rdata), 64'd0);
        check({tag, "_rsp"}, 64'({rsp_slverr, rsp_ruser, rsp_buser}), 64'd0);
    endtask

    // Single transfer from idle; cycle c counts negedges after the sampling edge
    task automatic run_trace(input int i, input int waits, input logic [3:0] strb_exp);
        @(posedge pclk);
        for (int c = 1; c <= 4 + waits; c++) begin
            @(negedge pclk);
            check("t_gnt", 64'(req_gnt[i]), 64'(c == 1));
            check("t_pwakeup", 64'(pwakeup), 64'(c <= 3 + waits));
            check("t_psel", 64'(psel), 64'(c >= 2 && c <= 3 + waits));
            check("t_penable", 64'(penable), 64'(c >= 3 && c <= 3 + waits));
            check("t_done", 64'(rsp_done[i]), 64'(c == 4 + waits));
            if (c >= 2 && c <= 3 + waits) begin
                check("t_paddr", 64'(paddr), 64'(req_addr[i]));
                check("t_pstrb", 64'(pstrb), 64'(strb_exp));
                check("t_pwrite", 64'(pwrite), 64'(req_write[i]));
                check("t_pwdata", 64'(pwdata), 64'(req_wdata[i]));
                check("t_pprot", 64'(pprot), 64'(req_prot[i]));
                check("t_pauser", 64'(pauser), 64'(req_auser[i]));
                check("t_pwuser", 64'(pwuser), 64'(req_wuser[i]));
            end
            if (c == 1) req_valid[i] = 1'b0;
        end
    endtask

    initial begin
        int ngnt;
        int ndone;
        bit reraised;

        presetn   = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        req_write = '0;
        req_wdata = '0;
        req_strb  = '0;
        req_prot  = '0;
        req_auser = '0;
        req_wuser = '0;
        prdata    = '0;
        pslverr   = 1'b0;
        pruser    = '0;
        pbuser    = '0;
        repeat (2) @(negedge pclk);
        check_all_zero("reset");
        @(posedge pclk);
        #1 presetn = 1'b1;

        // Single write from requester 2, zero wait states
        set_req(2, 32'h40, 1'b1, 32'hDEADBEEF, 4'hF, 3'b010, 4'h3, 4'h6);
        gnt_q.push_back(4'b0100);
        rsp_q.push_back('{4'b0100, 32'h0, 1'b0, 4'h0, 4'h0});
        req_valid[2] = 1'b1;
        run_trace(2, 0, 4'hF);

        // Read with 3 wait states: pstrb forced to 0, pwuser still passed through
        set_req(1, 32'h80, 1'b0, 32'h0, 4'hF, 3'b001, 4'h9, 4'h5);
        prdata = 32'h12345678;
        pruser = 4'h2;
        pbuser = 4'h1;
        wait_cfg = 3;
        gnt_q.push_back(4'b0010);
        rsp_q.push_back('{4'b0010, 32'h12345678, 1'b0, 4'h2, 4'h1});
        req_valid[1] = 1'b1;
        run_trace(1, 3, 4'h0);

        // Error response with user sidebands
        set_req(0, 32'hC0, 1'b1, 32'h55AA55AA, 4'h3, 3'b111, 4'hC, 4'hD);
        prdata  = 32'hFFFF0000;
        pslverr = 1'b1;
        pruser  = 4'hA;
        pbuser  = 4'h5;
        wait_cfg = 1;
        gnt_q.push_back(4'b0001);
        rsp_q.push_back('{4'b0001, 32'hFFFF0000, 1'b1, 4'hA, 4'h5});
        req_valid[0] = 1'b1;
        run_trace(0, 1, 4'h3);
        pslverr = 1'b0;

        // All requesters held valid out of reset: 0,1,2,3,0 back to back
        @(posedge pclk);
        #1 presetn = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_req(i, 32'h100 + 32'(i) * 4, 1'b1, 32'hA0 + 32'(i), 4'hF, 3'b000, 4'(i), 4'(i));
        end
        req_valid = 4'hF;
        prdata   = 32'hCAFE0000;
        pruser   = 4'h1;
        pbuser   = 4'h2;
        wait_cfg = 0;
        @(negedge pclk);
        check_all_zero("reset2");
        foreach (gnt_q[k]) check("stale_gnt_q", 64'(gnt_q.size()), 64'd0);
        gnt_q.push_back(4'b0001);
        gnt_q.push_back(4'b0010);
        gnt_q.push_back(4'b0100);
        gnt_q.push_back(4'b1000);
        gnt_q.push_back(4'b0001);
        rsp_q.push_back('{4'b0001, 32'hCAFE0000, 1'b0, 4'h1, 4'h2});
        rsp_q.push_back('{4'b0010, 32'hCAFE0000, 1'b0, 4'h1, 4'h2});
        rsp_q.push_back('{4'b0100, 32'hCAFE0000, 1'b0, 4'h1, 4'h2});
        rsp_q.push_back('{4'b1000, 32'hCAFE0000, 1'b0, 4'h1, 4'h2});
        rsp_q.push_back('{4'b0001, 32'hCAFE0000, 1'b0, 4'h1, 4'h2});
        @(posedge pclk);
        #1 presetn = 1'b1;
        @(posedge pclk);
        ngnt = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge pclk);
            if (req_gnt != '0) ngnt++;
            if (ngnt == 5) req_valid = '0;
            check("rr_pwakeup", 64'(pwakeup), 64'(c <= 11));
            check("rr_psel", 64'(psel), 64'(c >= 2 && c <= 11));
        end
        check("rr_grants", 64'(ngnt), 64'd5);

        // Reset mid-ACCESS with pready low: transfer abandoned, no rsp_done
        set_req(2, 32'h200, 1'b1, 32'h11112222, 4'hF, 3'b000, 4'h0, 4'h0);
        wait_cfg = 100;
        gnt_q.push_back(4'b0100);
        req_valid[2] = 1'b1;
        @(posedge pclk);
        for (int c = 1; c <= 4; c++) begin
            @(negedge pclk);
            if (c == 1) req_valid[2] = 1'b0;
        end
        check("in_access", 64'({psel, penable}), 64'h3);
        presetn = 1'b0;
        #1;
        check_all_zero("mid_access");
        set_req(3, 32'h300, 1'b0, 32'h0, 4'hF, 3'b100, 4'h7, 4'h8);
        req_valid = 4'b1000;
        prdata   = 32'h33330000;
        wait_cfg = 0;
        gnt_q.push_back(4'b1000);
        rsp_q.push_back('{4'b1000, 32'h33330000, 1'b0, 4'h1, 4'h2});
        @(posedge pclk);
        #1 presetn = 1'b1;
        run_trace(3, 0, 4'h0);

        // Requester 1 re-raises in its rsp_done cycle while 2 is pending
        set_req(1, 32'h410, 1'b1, 32'h41, 4'h1, 3'b000, 4'h1, 4'h1);
        set_req(2, 32'h420, 1'b1, 32'h42, 4'h2, 3'b000, 4'h2, 4'h2);
        prdata = 32'h0BADF00D;
        gnt_q.push_back(4'b0010);
        gnt_q.push_back(4'b0100);
        gnt_q.push_back(4'b0010);
        rsp_q.push_back('{4'b0010, 32'h0BADF00D, 1'b0, 4'h1, 4'h2});
        rsp_q.push_back('{4'b0100, 32'h0BADF00D, 1'b0, 4'h1, 4'h2});
        rsp_q.push_back('{4'b0010, 32'h0BADF00D, 1'b0, 4'h1, 4'h2});
        req_valid[1] = 1'b1;
        ndone    = 0;
        reraised = 1'b0;
        for (int c = 0; c < 40 && ndone < 3; c++) begin
            @(negedge pclk);
            if (req_gnt[1] && !reraised) req_valid[2] = 1'b1;
            req_valid = req_valid & ~req_gnt;
            if (rsp_done != '0) ndone++;
            if (rsp_done[1] && !reraised) begin
                req_valid[1] = 1'b1;
                reraised     = 1'b1;
            end
        end
        check("reraise_dones", 64'(ndone), 64'd3);

        repeat (3) @(negedge pclk);
        check("gnt_q_empty", 64'(gnt_q.size()), 64'd0);
        check("rsp_q_empty", 64'(rsp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/apb5_rev_d_arbiter.md
# apb5_rev_d_arbiter

Shares one APB5 (rev D) completer port among `NUM_REQ` on-chip requesters. Round-robin arbitration, latching of the winning request, full APB5 SETUP/ACCESS sequencing with `pwakeup` management, and return of read data, error and user response to the winner. Sits between bus-side requesters (DMA, debug, CPU bridge) and the APB5 peripheral fabric.

## Interface
- `NUM_REQ`, 4, number of requesters (2..16)
- `ADDR_WIDTH`, 32, `paddr` width
- `DATA_WIDTH`, 32, `pwdata`/`prdata` width (8, 16 or 32)
- `USER_REQ_WIDTH`, 4, `pauser` width
- `USER_DATA_WIDTH`, 4, `pwuser`/`pruser` width
- `USER_RESP_WIDTH`, 4, `pbuser` width

Ports, requester side, indexed `[NUM_REQ-1:0]`:
- `pclk  in  1  clock`
- `presetn  in  1  asynchronous active-low reset`
- `req_valid  in  NUM_REQ  request pending; held until matching `req_gnt``
- `req_addr, req_write, req_wdata, req_strb, req_prot, req_auser, req_wuser  in  per-requester [i][...]  transfer fields`
- `req_gnt  out  NUM_REQ  one-hot, one-cycle pulse: fields latched`
- `rsp_done  out  NUM_REQ  one-hot, one-cycle pulse: transfer complete`
- `rsp_rdata  out  DATA_WIDTH`, `rsp_slverr  out  1`, `rsp_ruser  out  USER_DATA_WIDTH`, `rsp_buser  out  USER_RESP_WIDTH`: valid only while any `rsp_done` bit is high

APB5 manager side: `paddr`, `pprot[2:0]`, `psel`, `penable`, `pwrite`, `pwdata`, `pstrb`, `pwakeup`, `pauser`, `pwuser` are outputs; `pready`, `prdata`, `pslverr`, `pruser`, `pbuser` are inputs.

## Operation
- FSM: IDLE, WAKE, SETUP, ACCESS.
- IDLE: if any `req_valid`, arbitrate, latch winner fields, pulse `req_gnt[w]`, go to WAKE. Otherwise stay.
- WAKE: `pwakeup`=1, `psel`=0, one cycle, then SETUP.
- SETUP: `psel`=1, `penable`=0, then ACCESS.
- ACCESS: `psel`=1, `penable`=1. Hold while `pready`=0; wait is unbounded.
- ACCESS with `pready`=1: capture `prdata/pslverr/pruser/pbuser` and pulse `rsp_done[w]` next cycle.
  - Any `req_valid` that cycle: arbitrate, grant, go directly to SETUP. `pwakeup` stays 1 and WAKE is skipped.
  - Otherwise go to IDLE. `pwakeup` drops.
- Arbitration happens only in IDLE or on ACCESS completion.
  - Round-robin: search starts at the index after the last winner. Pointer resets to 0, so requester 0 wins first.
  - A requester may re-raise `req_valid` after its `req_gnt`; it is serviced after every other pending requester.
- `pstrb` is driven 0 on reads (`req_write`=0) regardless of `req_strb`. `pwuser` is passed through on reads and writes.
- `pprot`, `pauser`, `paddr`, `pwrite`, `pwdata` come from latched registers. They are stable from SETUP through completion and hold their last value in IDLE/WAKE.
- `rsp_*` data fields hold their last value between `rsp_done` pulses.
- Reset (async assert, any state, including mid-ACCESS): FSM to IDLE, pointer to 0. All outputs reset to 0: `psel`, `penable`, `pwakeup`, `pwrite`, `paddr`, `pwdata`, `pstrb`, `pprot`, `pauser`, `pwuser`, `req_gnt`, `rsp_done`, `rsp_*`. An in-flight transfer is abandoned with no `rsp_done`. Deassertion is synchronised externally.

## Timing
- Edge 0 samples `req_valid` in IDLE. Then:
  - Cycle 1: `req_gnt` and `pwakeup`=1.
  - Cycle 2: SETUP.
  - Cycle 3: ACCESS.
  - `pready`=1 in cycle 3 gives `rsp_done` in cycle 4.
  - Minimum request-to-done latency: 4 cycles. Each wait state adds 1.
- Back-to-back: the next SETUP is in the same cycle as the previous `rsp_done`. Sustained throughput is 1 transfer / 2 cycles with zero wait states.
- `req_valid` is ignored in WAKE, SETUP and in ACCESS without `pready`.
- `pwakeup` rises one cycle before `psel`. It stays high continuously across back-to-back transfers and falls the cycle after the final completion.
- All outputs are registered. No combinational path from inputs to outputs.

## Structure
- Package `apb5_pkg`:
  - `apb5_state_e` enum (IDLE, WAKE, SETUP, ACCESS).
  - `PPROT_PRIV`/`PPROT_NONSEC`/`PPROT_INSTR` bit-index constants.
- Sub-module `apb5_rr_arbiter` (`NUM_REQ`, pointer register, `req` in, one-hot `gnt` + index out, `advance` strobe).
- Top `apb5_rev_d_arbiter`: FSM, field latches, response capture.

## Test plan
- Single write, requester 2, `req_addr`=0x40, `req_wdata`=0xDEADBEEF, `req_strb`=0xF, `pready`=1 → `req_gnt[2]` cycle 1, `psel` cycles 2–3, `penable` cycle 3, `rsp_done[2]` cycle 4, `rsp_slverr`=0.
- Read from 0x80 with 3 wait states, `req_strb`=0xF, `prdata`=0x12345678 → `pstrb`=0 throughout, `paddr` stable 5 cycles, `rsp_rdata`=0x12345678 at cycle 7.
- All 4 requesters held valid from reset → grant order 0,1,2,3,0. `pwakeup` high continuously. WAKE only before the first transfer.
- `pslverr`=1, `pbuser`=0x5, `pruser`=0xA at completion → `rsp_slverr`=1, `rsp_buser`=0x5, `rsp_ruser`=0xA with `rsp_done`.
- `presetn` low during ACCESS with `pready`=0 → all outputs 0 immediately, no `rsp_done`. After release, a pending request from requester 3 is granted with pointer restarted at 0.
- Requester 1 re-raises `req_valid` in its `rsp_done` cycle while requester 2 is pending → requester 2 is granted next.
